// File: rtl/dsp_pkg.sv
// Shared types and saturation helpers for the DSP multiply-accumulate slice.
package dsp_pkg;

  typedef enum logic [1:0] {
    MODE_MUL    = 2'd0,
    MODE_MAC    = 2'd1,
    MODE_PREADD = 2'd2,
    MODE_PRESUB = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } frame_state_e;

  // Widest signed quantity the saturation helpers can describe.
  localparam int SAT_W = 128;

  // Largest signed value representable in w bits, sign-extended to SAT_W.
  function automatic logic signed [SAT_W-1:0] sat_max(input int w);
    logic signed [SAT_W-1:0] one;
    one = SAT_W'(1);
    return (one <<< (w - 1)) - one;
  endfunction

  // Smallest signed value representable in w bits, sign-extended to SAT_W.
  function automatic logic signed [SAT_W-1:0] sat_min(input int w);
    logic signed [SAT_W-1:0] one;
    one = SAT_W'(1);
    return -(one <<< (w - 1));
  endfunction

endpackage

// File: rtl/dsp_round_sat.sv
// Combinational round-half-up, arithmetic right shift and clamp to OUT_W.
// The clamp flag reports saturation in either the rounding add or the clamp.
module dsp_round_sat
  import dsp_pkg::*;
#(
  parameter int IN_W  = 48,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clamp
);

  logic signed [IN_W-1:0] shifted;
  logic                   rnd_sat;
  logic                   out_sat;

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [IN_W-1:0] IN_MAX = IN_W'(sat_max(IN_W));
      logic signed [IN_W:0]   half;
      logic signed [IN_W:0]   sum;
      logic signed [IN_W-1:0] pre;

      // Add half an output LSB one bit wider, so a carry into the sign is seen.
      always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        half            = '0;
        half[SHIFT-1]   = 1'b1;
        sum             = {din[IN_W-1], din} + half;
        // Only a positive operand can overflow when adding a positive constant.
        rnd_sat         = (sum[IN_W] != sum[IN_W-1]);
        pre             = rnd_sat ? IN_MAX : sum[IN_W-1:0];
        shifted         = pre >>> SHIFT;
      end
    end else begin : g_no_round
      assign rnd_sat = 1'b0;
      assign shifted = din;
    end

    if (OUT_W < IN_W) begin : g_clamp
      localparam logic signed [IN_W-1:0] O_MAX = IN_W'(sat_max(OUT_W));
      localparam logic signed [IN_W-1:0] O_MIN = IN_W'(sat_min(OUT_W));

      // Clamp the shifted value into the signed OUT_W range.
      always_comb begin
        out_sat = 1'b1;
        if (shifted > O_MAX)      dout = O_MAX[OUT_W-1:0];
        else if (shifted < O_MIN) dout = O_MIN[OUT_W-1:0];
        else begin
          dout    = shifted[OUT_W-1:0];
          out_sat = 1'b0;
        end
      end
    end else begin : g_widen
      assign dout    = OUT_W'(shifted);
      assign out_sat = 1'b0;
    end
  endgenerate

  assign clamp = rnd_sat | out_sat;

endmodule

// File: rtl/dsp_mac_pipe.sv
// Pipelined signed multiply-accumulate with optional pre-adder. Beats are
// framed by IN_LAST; each frame yields one rounded, saturated result.
// Pipeline: S1 input regs, S2 pre-add reg, optional product reg, S3 acc, S4 out.
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int A_W   = 18,
  parameter int B_W   = 18,
  parameter int ACC_W = 48,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0,
  parameter int MREG  = 1,
  parameter int CNT_W = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CE,
  input  logic                    IN_VALID,
  input  logic                    IN_LAST,
  input  logic [1:0]              MODE,
  input  logic signed [A_W-1:0]   A,
  input  logic signed [B_W-1:0]   B,
  input  logic signed [B_W-1:0]   D,
  output logic                    OUT_VALID,
  output logic signed [OUT_W-1:0] OUT_P,
  output logic                    OUT_OVF,
  output logic [CNT_W-1:0]        OUT_CNT,
  output logic                    BUSY
);

  localparam int PRE_W  = B_W + 1;
  localparam int PROD_W = A_W + B_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

  // ---------------- frame tracking at the input ----------------
  frame_state_e state;
  mode_e        frame_mode;
  logic         first_beat;
  mode_e        eff_mode;
  logic         eff_last;

  // A beat in IDLE opens a frame and supplies its mode; a MUL beat is a whole frame.
  always_comb begin
    first_beat = (state == IDLE);
    eff_mode   = first_beat ? mode_e'(MODE) : frame_mode;
    eff_last   = IN_LAST || (eff_mode == MODE_MUL);
  end

  // Two-state frame FSM with registered BUSY; bubbles leave it untouched.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      state      <= IDLE;
      frame_mode <= MODE_MUL;
      BUSY       <= 1'b0;
    end else if (CE && IN_VALID) begin
      if (first_beat) frame_mode <= mode_e'(MODE);
      if (eff_last) begin
        state <= IDLE;
        BUSY  <= 1'b0;
      end else begin
        state <= OPEN;
        BUSY  <= 1'b1;
      end
    end
  end

  // ---------------- S1: input registers ----------------
  logic                  vld1, first1, last1;
  mode_e                 mode1;
  logic signed [A_W-1:0] a1;
  logic signed [B_W-1:0] b1, d1;

  // S1 control: beat qualifiers, cleared by reset so in-flight beats are dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld1   <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
    end else if (CE) begin
      vld1   <= IN_VALID;
      first1 <= first_beat;
      last1  <= eff_last;
    end
  end

  // S1 data: operands and the frame's effective mode.
  always_ff @(posedge CLK) begin
    // NOTE: datapath registers carry no reset; they are only consumed when their valid is set.
    if (CE) begin
      mode1 <= eff_mode;
      a1    <= A;
      b1    <= B;
      d1    <= D;
    end
  end

  // ---------------- S2: pre-adder ----------------
  logic signed [PRE_W-1:0] pre, pre2;
  logic signed [A_W-1:0]   a2;
  logic                    vld2, first2, last2;

  // Pre-add at B_W+1 bits so D+B and D-B never wrap.
  always_comb begin
    case (mode1)
      MODE_PREADD: pre = PRE_W'(d1) + PRE_W'(b1);
      MODE_PRESUB: pre = PRE_W'(d1) - PRE_W'(b1);
      default:     pre = PRE_W'(b1);
    endcase
  end

  // S2 control qualifiers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld2   <= 1'b0;
      first2 <= 1'b0;
      last2  <= 1'b0;
    end else if (CE) begin
      vld2   <= vld1;
      first2 <= first1;
      last2  <= last1;
    end
  end

  // S2 data: pre-add result and the multiplicand travelling alongside it.
  always_ff @(posedge CLK) begin
    if (CE) begin
      pre2 <= pre;
      a2   <= a1;
    end
  end

  // ---------------- multiplier (optionally registered) ----------------
  logic signed [PROD_W-1:0] prod, prod_m;
  logic                     vld_m, first_m, last_m;

  assign prod = PROD_W'(a2) * PROD_W'(pre2);

  generate
    if (MREG != 0) begin : g_mreg
      // Product register stage: control qualifiers.
      always_ff @(posedge CLK) begin
        if (RST) begin
          vld_m   <= 1'b0;
          first_m <= 1'b0;
          last_m  <= 1'b0;
        end else if (CE) begin
          vld_m   <= vld2;
          first_m <= first2;
          last_m  <= last2;
        end
      end

      // Product register stage: data.
      always_ff @(posedge CLK) begin
        if (CE) prod_m <= prod;
      end
    end else begin : g_no_mreg
      assign vld_m   = vld2;
      assign first_m = first2;
      assign last_m  = last2;
      assign prod_m  = prod;
    end
  endgenerate

  // ---------------- S3: saturating accumulator ----------------
  logic signed [ACC_W-1:0] acc, acc_next, prod_x;
  logic signed [ACC_W:0]   sum;
  logic                    acc_ovf, sticky, fin3;
  logic [CNT_W-1:0]        cnt, cnt_next;

  // One extra bit exposes signed overflow; clamp toward the addend's sign.
  always_comb begin
    prod_x   = ACC_W'(prod_m);
    sum      = {acc[ACC_W-1], acc} + {prod_x[ACC_W-1], prod_x};
    acc_ovf  = (sum[ACC_W] != sum[ACC_W-1]);
    acc_next = acc_ovf ? (prod_x[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    cnt_next = (&cnt) ? cnt : cnt + 1'b1;
  end

  // Accumulate each valid beat; the first beat of a frame restarts acc, count and sticky.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc    <= '0;
      sticky <= 1'b0;
      cnt    <= '0;
      fin3   <= 1'b0;
    end else if (CE) begin
      fin3 <= vld_m && last_m;
      if (vld_m) begin
        if (first_m) begin
          acc    <= prod_x;
          sticky <= 1'b0;
          cnt    <= CNT_W'(1);
        end else begin
          acc    <= acc_next;
          sticky <= sticky | acc_ovf;
          cnt    <= cnt_next;
        end
      end
    end
  end

  // ---------------- S4: round / saturate output ----------------
  logic signed [OUT_W-1:0] rs_out;
  logic                    rs_clamp;

  dsp_round_sat #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_round_sat (
    .din   (acc),
    .dout  (rs_out),
    .clamp (rs_clamp)
  );

  // Capture the finished frame's result; the result holds until the next one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      OUT_P     <= '0;
      OUT_OVF   <= 1'b0;
      OUT_CNT   <= '0;
    end else if (CE) begin
      OUT_VALID <= fin3;
      if (fin3) begin
        OUT_P   <= rs_out;
        OUT_OVF <= sticky | rs_clamp;
        OUT_CNT <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe. Five instances share one stimulus stream:
// defaults, MREG=0, ACC_W=40, SHIFT=2 and CNT_W=2.
module tb_dsp_mac_pipe;

  logic               clk = 1'b0;
  logic               rst, ce, in_valid, in_last;
  logic [1:0]         mode;
  logic signed [17:0] a, b, d;

  logic               ov0, ovf0, busy0;
  logic signed [31:0] p0;
  logic [15:0]        cnt0;
  logic               ov1, ovf1, busy1;
  logic signed [31:0] p1;
  logic [15:0]        cnt1;
  logic               ov2, ovf2, busy2;
  logic signed [31:0] p2;
  logic [15:0]        cnt2;
  logic               ov3, ovf3, busy3;
  logic signed [31:0] p3;
  logic [15:0]        cnt3;
  logic               ov4, ovf4, busy4;
  logic signed [31:0] p4;
  logic [1:0]         cnt4;

  int errors = 0;
  int checks = 0;
  int cyc;
  logic seen;

  always #5 clk = ~clk;

  dsp_mac_pipe dut (
    .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid), .IN_LAST(in_last),
    .MODE(mode), .A(a), .B(b), .D(d), .OUT_VALID(ov0), .OUT_P(p0),
    .OUT_OVF(ovf0), .OUT_CNT(cnt0), .BUSY(busy0));

  dsp_mac_pipe #(.MREG(0)) dut_m0 (
    .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid), .IN_LAST(in_last),
    .MODE(mode), .A(a), .B(b), .D(d), .OUT_VALID(ov1), .OUT_P(p1),
    .OUT_OVF(ovf1), .OUT_CNT(cnt1), .BUSY(busy1));

  dsp_mac_pipe #(.ACC_W(40)) dut_sat (
    .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid), .IN_LAST(in_last),
    .MODE(mode), .A(a), .B(b), .D(d), .OUT_VALID(ov2), .OUT_P(p2),
    .OUT_OVF(ovf2), .OUT_CNT(cnt2), .BUSY(busy2));

  dsp_mac_pipe #(.SHIFT(2)) dut_rnd (
    .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid), .IN_LAST(in_last),
    .MODE(mode), .A(a), .B(b), .D(d), .OUT_VALID(ov3), .OUT_P(p3),
    .OUT_OVF(ovf3), .OUT_CNT(cnt3), .BUSY(busy3));

  dsp_mac_pipe #(.CNT_W(2)) dut_c2 (
    .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(in_valid), .IN_LAST(in_last),
    .MODE(mode), .A(a), .B(b), .D(d), .OUT_VALID(ov4), .OUT_P(p4),
    .OUT_OVF(ovf4), .OUT_CNT(cnt4), .BUSY(busy4));

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 time unit before sampling outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic l, input logic [1:0] m,
                       input int av, input int bv, input int dv);
    in_valid = v;
    in_last  = l;
    mode     = m;
    a        = 18'(av);
    b        = 18'(bv);
    d        = 18'(dv);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 0, 0, 0);
  endtask

  // Bounded wait for the default instance's OUT_VALID; cyc counts edges waited.
  task automatic wait_out(output int n);
    n = 0;
    while (ov0 !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_valid", ov0, 0);
    check("rst_p", p0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_cnt", cnt0, 0);
    check("rst_busy", busy0, 0);

    // MUL beat with IN_LAST=0 is still a one-beat frame.
    drive(1'b1, 1'b0, 2'd0, -3, 7, 0);
    tick();
    check("mul_busy", busy0, 0);
    idle();
    tick();
    tick();
    tick();
    check("mul_m0_valid", ov1, 1);
    check("mul_m0_p", p1, -21);
    check("mul_early_valid", ov0, 0);
    tick();
    check("mul_valid", ov0, 1);
    check("mul_p", p0, -21);
    check("mul_cnt", cnt0, 1);
    check("mul_ovf", ovf0, 0);
    check("mul_m0_pulse", ov1, 0);
    tick();
    check("mul_pulse", ov0, 0);
    check("mul_hold", p0, -21);

    // MAC of 4 beats with a bubble after beat 2.
    drive(1'b1, 1'b0, 2'd1, 2, 1, 0);
    tick();
    check("mac_busy1", busy0, 1);
    drive(1'b1, 1'b0, 2'd1, 2, 2, 0);
    tick();
    idle();
    tick();
    check("mac_busy_bubble", busy0, 1);
    drive(1'b1, 1'b0, 2'd1, 2, 3, 0);
    tick();
    check("mac_busy3", busy0, 1);
    drive(1'b1, 1'b1, 2'd1, 2, 4, 0);
    tick();
    check("mac_busy_end", busy0, 0);
    idle();
    wait_out(cyc);
    check("mac_latency", cyc, 4);
    check("mac_p", p0, 20);
    check("mac_cnt", cnt0, 4);
    check("mac_cnt_sat2", cnt4, 3);
    check("mac_ovf", ovf0, 0);
    tick();

    // Mid-frame MODE change is ignored: 2*3 + 2*3, not 2*3 + 2*103.
    drive(1'b1, 1'b0, 2'd1, 2, 3, 100);
    tick();
    drive(1'b1, 1'b1, 2'd2, 2, 3, 100);
    tick();
    idle();
    wait_out(cyc);
    check("latch_p", p0, 12);
    check("latch_cnt", cnt0, 2);
    tick();

    // Back-to-back PREADD then PRESUB one-beat frames.
    drive(1'b1, 1'b1, 2'd2, 3, 4, 10);
    tick();
    drive(1'b1, 1'b1, 2'd3, 3, 4, 10);
    tick();
    idle();
    tick();
    tick();
    tick();
    check("preadd_valid", ov0, 1);
    check("preadd_p", p0, 42);
    tick();
    check("presub_valid", ov0, 1);
    check("presub_p", p0, 18);
    check("presub_cnt", cnt0, 1);
    tick();

    // Accumulator saturation: 34 beats of (-2^17)*(-2^17) = 2^34 each.
    for (int i = 0; i < 34; i++) begin
      drive(1'b1, (i == 33), 2'd1, -131072, -131072, 0);
      tick();
    end
    idle();
    wait_out(cyc);
    check("sat_p", p2, 2147483647);
    check("sat_ovf", ovf2, 1);
    check("sat_cnt", cnt2, 34);
    check("sat48_p", p0, 2147483647);
    check("sat48_ovf", ovf0, 1);
    tick();
    drive(1'b1, 1'b1, 2'd1, 1, 1, 0);
    tick();
    idle();
    wait_out(cyc);
    check("after_sat_p", p2, 1);
    check("after_sat_ovf", ovf2, 0);
    tick();

    // Round half up with SHIFT=2, one-beat MUL frames back to back.
    drive(1'b1, 1'b0, 2'd0, 1, 6, 0);
    tick();
    drive(1'b1, 1'b0, 2'd0, 1, -6, 0);
    tick();
    drive(1'b1, 1'b0, 2'd0, 1, -7, 0);
    tick();
    drive(1'b1, 1'b0, 2'd0, 1, 2, 0);
    tick();
    idle();
    tick();
    check("rnd_6", p3, 2);
    check("rnd_6_main", p0, 6);
    tick();
    check("rnd_m6", p3, -1);
    tick();
    check("rnd_m7", p3, -2);
    tick();
    check("rnd_2", p3, 1);
    tick();

    // Clock enable freezes everything, including an accepted-looking beat.
    drive(1'b1, 1'b0, 2'd0, 5, 5, 0);
    tick();
    idle();
    tick();
    tick();
    tick();
    ce = 1'b0;
    drive(1'b1, 1'b0, 2'd1, 1, 1, 0);
    tick();
    tick();
    tick();
    check("ce_frozen_valid", ov0, 0);
    check("ce_frozen_busy", busy0, 0);
    idle();
    ce = 1'b1;
    tick();
    check("ce_valid", ov0, 1);
    check("ce_p", p0, 25);
    ce = 1'b0;
    tick();
    check("ce_hold_pulse", ov0, 1);
    ce = 1'b1;
    tick();
    check("ce_pulse_end", ov0, 0);

    // Reset after beat 2 of a 5-beat frame aborts it cleanly.
    drive(1'b1, 1'b0, 2'd1, 1, 1, 0);
    tick();
    drive(1'b1, 1'b0, 2'd1, 1, 1, 0);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy0, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | ov0;
    end
    check("abort_no_valid", seen, 0);
    drive(1'b1, 1'b0, 2'd1, 1, 5, 0);
    tick();
    drive(1'b1, 1'b1, 2'd1, 1, 7, 0);
    tick();
    idle();
    wait_out(cyc);
    check("restart_latency", cyc, 4);
    check("restart_p", p0, 12);
    check("restart_cnt", cnt0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
